// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and sizes for the instruction-memory loader
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int IMEM_WORDS = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } loader_state_e;

endpackage

// File: rtl/imem_loader_packer.sv
// imem_word_packer: gathers four little-endian bytes into one 32-bit word
module imem_word_packer
    import riscv_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clr_i,
    input  logic            accept_i,
    input  logic [7:0]      byte_i,
    output logic [XLEN-1:0] word_o,
    output logic            last_o
);

    logic [1:0]      idx_q, idx_d;
    logic [XLEN-1:0] word_q, word_d;

    // shift each new byte in from the top so byte 0 ends up in bits [7:0]
    always_comb begin
        idx_d  = clr_i ? 2'd0 : (accept_i ? idx_q + 2'd1 : idx_q);
        word_d = clr_i ? '0 : (accept_i ? {byte_i, word_q[XLEN-1:8]} : word_q);
    end

    // index and word registers, discarded on reset or clear
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q  <= 2'd0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

    assign word_o = word_q;
    assign last_o = accept_i && (idx_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams a byte image into IMEM as 32-bit words and stalls the PC meanwhile
module imem_loader
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] BASE_ADDR = 32'h0000_0000,
    parameter int              MAX_WORDS = IMEM_WORDS,
    parameter int              LEN_W     = 11
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             byte_valid_i,
    input  logic [7:0]       byte_data_i,
    output logic             byte_ready_o,
    output logic             mem_we_o,
    output logic [XLEN-1:0]  mem_addr_o,
    output logic [XLEN-1:0]  mem_data_o,
    output logic             pc_we_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    loader_state_e    state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  addr_q, addr_d;
    logic             err_q, err_d;
    logic             clr, accept, last;

    imem_word_packer u_packer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (clr),
        .accept_i(accept),
        .byte_i  (byte_data_i),
        .word_o  (mem_data_o),
        .last_o  (last)
    );

    // next-state, length latch, word counter and address generation
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        err_d   = 1'b0;
        clr     = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                clr = 1'b1;
                if (start_i) begin
                    if (len_i == '0) begin
                        state_d = DONE;
                    end else if (len_i > LEN_W'(MAX_WORDS)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = RECV;
                        len_d   = len_i;
                        cnt_d   = '0;
                        addr_d  = BASE_ADDR;
                    end
                end
            end
            RECV: begin
                accept  = byte_valid_i;
                state_d = last ? WRITE : RECV;
            end
            WRITE: begin
                clr     = 1'b1;
                cnt_d   = cnt_q + LEN_W'(1);
                addr_d  = addr_q + XLEN'(4);
                state_d = (cnt_q + LEN_W'(1) == len_q) ? DONE : RECV;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= BASE_ADDR;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    assign byte_ready_o = (state_q == RECV);
    assign mem_we_o     = (state_q == WRITE);
    assign mem_addr_o   = addr_q;
    assign pc_we_o      = (state_q == IDLE);
    assign busy_o       = (state_q == RECV) || (state_q == WRITE);
    assign done_o       = (state_q == DONE);
    assign err_o        = err_q;

endmodule
